// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin burst arbiter sharing one S-RAM port among three RC4 engines
// Ports: clk/reset (async, active-high); req/wren_in/addr_in/wdata_in per requester;
//   gnt one-hot registered grant; rvalid/rdata read returns routed to the issuer;
//   mem_addr/mem_data/mem_wren/mem_q to the S-RAM; busy high while granted or draining.
module s_mem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          req,
   input  logic [2:0]          wren_in,
   input  logic [3*ADDR_W-1:0] addr_in,
   input  logic [3*DATA_W-1:0] wdata_in,
   output logic [2:0]          gnt,
   output logic [2:0]          rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_data,
   output logic                mem_wren,
   input  logic [DATA_W-1:0]   mem_q,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
   state_t state;
   logic [ADDR_W-1:0] a [3];
   logic [DATA_W-1:0] d [3];
   logic [1:0] rr_ptr, own, nxt_ptr, r1, r2, pick;
   logic has_gnt, issue, rd_issue;
   // read-return pipe: valid bits and issuing owner, one stage per cycle of latency
   logic [READ_LATENCY-1:0] pv, pv_nxt;
   logic [1:0] po [READ_LATENCY];
   for (genvar i = 0; i < 3; i++) begin : g_split
      assign a[i] = addr_in[ADDR_W*i +: ADDR_W];
      assign d[i] = wdata_in[DATA_W*i +: DATA_W];
   end
   always_comb begin
      own      = gnt[1] ? 2'd1 : gnt[2] ? 2'd2 : 2'd0;
      has_gnt  = |gnt;
      issue    = has_gnt & req[own];
      rd_issue = issue & ~wren_in[own];
      mem_addr = has_gnt ? a[own] : '0;
      mem_data = has_gnt ? d[own] : '0;
      mem_wren = issue & wren_in[own];
      nxt_ptr  = own == 2'd2 ? 2'd0 : own + 2'd1;
      r1       = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
      r2       = rr_ptr == 2'd0 ? 2'd2 : rr_ptr - 2'd1;
      pick     = req[rr_ptr] ? rr_ptr : req[r1] ? r1 : r2;
      pv_nxt   = (pv << 1) | READ_LATENCY'(rd_issue);
      rvalid   = pv[READ_LATENCY-1] ? 3'b001 << po[READ_LATENCY-1] : 3'b000;
      rdata    = mem_q;
      busy     = state != IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         gnt    <= '0;
         rr_ptr <= '0;
         pv     <= '0;
         for (int i = 0; i < READ_LATENCY; i++) po[i] <= '0;
      end else begin
         pv    <= pv_nxt;
         po[0] <= own;
         for (int i = 1; i < READ_LATENCY; i++) po[i] <= po[i-1];
         case (state)
            IDLE: if (|req) begin
               gnt   <= 3'b001 << pick;
               state <= GRANT;
            end
            // hand-off waits for outstanding reads so returns never cross owners
            GRANT: if (!req[own]) begin
               gnt    <= '0;
               rr_ptr <= nxt_ptr;
               state  <= |pv_nxt ? DRAIN : IDLE;
            end
            DRAIN: if (!(|pv_nxt)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: randomized and directed bench for s_mem_arbiter against a timeline reference model
module tb_s_mem_arbiter;
   localparam int RL = 3;
   typedef struct {int cyc; int own; logic [7:0] d;} ret_t;
   logic clk = 1'b0, reset = 1'b1;
   logic [2:0] req = '0, wren_in = '0;
   logic [23:0] addr_in = '0, wdata_in = '0;
   logic [2:0] gnt, rvalid;
   logic [7:0] rdata, mem_addr, mem_data, mem_q;
   logic mem_wren, busy;
   logic [7:0] sram [256];
   logic [7:0] qp [RL];
   logic [7:0] ref_mem [256];
   ret_t rq [$];
   logic [2:0] m_gnt = '0, p_req = '0;
   int cyc = 0, idle_from = 0, last_ret = -100, last = 2;
   int n_chk = 0, n_pass = 0, dut_wr = 0, rv1 = 0;
   int bl [3];
   bit st [3];
   s_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .req(req), .wren_in(wren_in), .addr_in(addr_in),
      .wdata_in(wdata_in), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
   );
   always #5 clk = ~clk;
   assign mem_q = qp[RL-1];
   always @(posedge clk) begin
      if (mem_wren) sram[mem_addr] <= mem_data;
      qp[0] <= sram[mem_addr];
      for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      else n_pass++;
   endtask
   function automatic int oh2i(input logic [2:0] g);
      return g[1] ? 1 : g[2] ? 2 : 0;
   endfunction
   function automatic logic [7:0] a_of(input int k);
      return addr_in[8*k +: 8];
   endfunction
   function automatic logic [7:0] d_of(input int k);
      return wdata_in[8*k +: 8];
   endfunction
   task automatic drv(input int k, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
      req[k] = r;
      wren_in[k] = w;
      addr_in[8*k +: 8] = a;
      wdata_in[8*k +: 8] = d;
   endtask
   task automatic tick();
      int k;
      logic [2:0] erv;
      logic [7:0] ed;
      @(negedge clk);
      k = oh2i(m_gnt);
      chk("gnt", gnt, m_gnt);
      chk("busy", busy, 32'(m_gnt != 0 || cyc < idle_from));
      erv = '0;
      ed = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         erv = 3'b001 << rq[0].own;
         ed = rq[0].d;
         void'(rq.pop_front());
      end
      chk("rvalid", rvalid, erv);
      if (erv != 0) chk("rdata", rdata, ed);
      if (rvalid[1]) rv1++;
      if (mem_wren) dut_wr++;
      if (m_gnt != 0) begin
         chk("mem_addr", mem_addr, a_of(k));
         chk("mem_wren", mem_wren, req[k] & wren_in[k]);
         if (req[k] & wren_in[k]) chk("mem_data", mem_data, d_of(k));
         if (req[k]) begin
            if (wren_in[k]) ref_mem[a_of(k)] = d_of(k);
            else begin
               rq.push_back('{cyc + RL, k, ref_mem[a_of(k)]});
               last_ret = cyc + RL;
            end
         end
      end else begin
         chk("mem_wren_idle", mem_wren, 0);
         chk("mem_addr_idle", mem_addr, 0);
         chk("mem_data_idle", mem_data, 0);
      end
      p_req = req;
      @(posedge clk);
      #1;
      cyc++;
      if (m_gnt != 0) begin
         if (!p_req[k]) begin
            last = k;
            m_gnt = '0;
            idle_from = (cyc > last_ret + 1) ? cyc : last_ret + 1;
         end
      end else if (cyc - 1 >= idle_from && p_req != 0) begin
         for (int o = 1; o <= 3; o++)
            if (m_gnt == 0 && p_req[(last + o) % 3]) m_gnt = 3'b001 << ((last + o) % 3);
      end
   endtask
   task automatic wait_gnt(input int k);
      for (int n = 0; n < 12 && !m_gnt[k]; n++) tick();
      chk("grant_wait", gnt[k], 1);
   endtask
   task automatic drain();
      req = '0;
      wren_in = '0;
      repeat (RL + 4) tick();
      for (int k = 0; k < 3; k++) st[k] = 0;
   endtask
   task automatic step_rand(input int p_raise, input int fixed);
      for (int k = 0; k < 3; k++) begin
         if (m_gnt[k]) begin
            if (!st[k]) begin
               st[k] = 1;
               bl[k] = fixed != 0 ? fixed : int'($urandom_range(1, 4));
            end
            if (bl[k] > 0) begin
               bl[k]--;
               drv(k, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end else begin
               req[k] = 0;
               st[k] = 0;
            end
         end else begin
            st[k] = 0;
            drv(k, req[k] | ($urandom_range(0, 99) < p_raise), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         end
      end
      tick();
   endtask
   initial begin
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_addr", mem_addr, 0);
      @(posedge clk);
      #1;
      reset = 0;
      // init pass: requester 0 loads S[i]=i
      drv(0, 1, 0, 0, 0);
      drv(1, 0, 1, 8'd200, 8'd77);
      wait_gnt(0);
      for (int i = 0; i < 256; i++) begin
         drv(0, 1, 1, 8'(i), 8'(i));
         tick();
      end
      req[0] = 0;
      tick();
      chk("init_writes", dut_wr, 256);
      drain();
      // requester 1 reads 5,6,7 while non-owner 2 drives a write to 9
      rv1 = 0;
      drv(1, 1, 0, 8'd5, 0);
      drv(2, 0, 1, 8'd9, 8'hee);
      wait_gnt(1);
      for (int i = 5; i < 8; i++) begin
         drv(1, 1, 0, 8'(i), 0);
         tick();
      end
      req[1] = 0;
      repeat (RL + 3) tick();
      chk("rv1_count", rv1, 3);
      drain();
      // requester 2 reads then drops while requester 0 waits: drain before hand-off
      drv(2, 1, 0, 8'd7, 0);
      wait_gnt(2);
      tick();
      drv(2, 0, 0, 0, 0);
      drv(0, 1, 0, 8'd1, 0);
      tick();
      repeat (12) step_rand(0, 2);
      drain();
      // all requesters persistent, two beats each: rotation with gaps
      repeat (40) step_rand(100, 2);
      drain();
      repeat (3000) step_rand(40, 0);
      drain();
      // reset one cycle after a read issues; the pending return must vanish
      drv(1, 1, 0, 8'd42, 0);
      wait_gnt(1);
      tick();
      drv(1, 1, 1, 8'd43, 8'h55);
      #2 reset = 1;
      #1;
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wren", mem_wren, 0);
      @(posedge clk);
      #1;
      reset = 0;
      req = '0;
      wren_in = '0;
      rq.delete();
      m_gnt = '0;
      last = 2;
      cyc++;
      idle_from = cyc;
      last_ret = -100;
      repeat (RL + 5) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
